// File: rtl/wordmux_arb.sv
// Registered one-entry word multiplexer: fixed-select or round-robin choice of one input channel per cycle.
// Optional sticky round-robin lock is built when WORDMUX_ARB_LOCK_EN is defined (adds port i_lock).
module wordmux_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [CHANNELS*WIDTH-1:0] i_val,
  input  logic [CHANNELS-1:0]       i_valid,
`ifdef WORDMUX_ARB_LOCK_EN
  input  logic                      i_lock,
`endif
  output logic [CHANNELS-1:0]       o_ready,
  output logic [WIDTH-1:0]          o_val,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [SEL_W-1:0]          o_grant
);

  localparam int SLOTS = 2 ** SEL_W;

  // Inputs padded out to the full select range so any SEL_W index is in bounds.
  logic [WIDTH-1:0] words [SLOTS];
  logic [SLOTS-1:0] valid_pad;
  logic [SLOTS-1:0] ready_pad;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_words
      if (gi < CHANNELS) begin : g_real
        assign words[gi] = i_val[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign words[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    valid_pad = '0;
    valid_pad[CHANNELS-1:0] = i_valid;
  end

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] cand;
  logic             cand_ok;
  logic             ld;
  logic             grant;
  int               idx;

`ifdef WORDMUX_ARB_LOCK_EN
  logic             r_locked;
  logic [SEL_W-1:0] lock_ch;
`endif

  assign ld    = !o_valid || i_ready;
  assign grant = ld && cand_ok;

  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    idx     = 0;
    if (!i_mode) begin
      cand = i_sel;
      cand_ok = (int'(i_sel) < CHANNELS) && valid_pad[i_sel];
    end else begin
      // Scan downward so the last hit is the first valid channel at or after r_ptr.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        idx = int'(r_ptr) + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (valid_pad[idx[SEL_W-1:0]]) begin
          cand_ok = 1'b1;
          cand    = idx[SEL_W-1:0];
        end
      end
`ifdef WORDMUX_ARB_LOCK_EN
      if (r_locked) begin
        cand    = lock_ch;
        cand_ok = valid_pad[lock_ch];
      end
`endif
    end
  end

  always_comb begin
    ready_pad = '0;
    if (!i_rst && grant) ready_pad[cand] = 1'b1;
  end

  assign o_ready = ready_pad[CHANNELS-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_val   <= '0;
      o_grant <= '0;
      o_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (ld) begin
      if (cand_ok) begin
        o_val   <= words[cand];
        o_grant <= cand;
        o_valid <= 1'b1;
        if (i_mode) begin
          r_ptr <= (cand == SEL_W'(CHANNELS - 1)) ? '0 : cand + 1'b1;
        end
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef WORDMUX_ARB_LOCK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_locked <= 1'b0;
      lock_ch  <= '0;
    end else if (!i_mode) begin
      r_locked <= 1'b0;
    end else if (grant) begin
      r_locked <= i_lock;
      lock_ch  <= cand;
    end
  end
`endif

endmodule

// File: tb/tb_wordmux_arb.sv
// Directed bench for wordmux_arb: a sequential vector table plus reset-mid-transfer and lock sequences.
module tb_wordmux_arb;

  localparam int WIDTH = 16;
  localparam int CH    = 4;
  localparam int SW    = 3;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_mode;
  logic [SW-1:0]     i_sel;
  logic [CH*WIDTH-1:0] i_val;
  logic [CH-1:0]     i_valid;
  logic [CH-1:0]     o_ready;
  logic [WIDTH-1:0]  o_val;
  logic              o_valid;
  logic              i_ready;
  logic [SW-1:0]     o_grant;
`ifdef WORDMUX_ARB_LOCK_EN
  logic              i_lock = 1'b0;
`endif

  wordmux_arb #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_sel(i_sel),
    .i_val(i_val), .i_valid(i_valid),
`ifdef WORDMUX_ARB_LOCK_EN
    .i_lock(i_lock),
`endif
    .o_ready(o_ready), .o_val(o_val), .o_valid(o_valid),
    .i_ready(i_ready), .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          mode;
    logic [SW-1:0] sel;
    logic [CH-1:0] valid;
    logic          rdy;
    logic [15:0]   w2;
    logic [CH-1:0] ex_ready;
    logic [15:0]   ex_val;
    logic [SW-1:0] ex_grant;
    logic          ex_valid;
  } vec_t;

  vec_t tbl[19];

  // One cycle: drive just after an edge, check o_ready before the next, registers after it.
  task automatic step(input string tag, input logic [CH-1:0] ex_ready,
                      input logic [15:0] ex_val, input logic [SW-1:0] ex_grant, input logic ex_valid);
    #3;
    chk({tag, ".o_ready"}, 32'(o_ready), 32'(ex_ready));
    @(posedge i_clk);
    #1;
    chk({tag, ".o_val"}, 32'(o_val), 32'(ex_val));
    chk({tag, ".o_grant"}, 32'(o_grant), 32'(ex_grant));
    chk({tag, ".o_valid"}, 32'(o_valid), 32'(ex_valid));
    $display("%s: mode=%0d sel=%0d valid=%b rdy=%0d -> ready=%b val=%h grant=%0d ovalid=%0d",
             tag, i_mode, i_sel, i_valid, i_ready, o_ready, o_val, o_grant, o_valid);
  endtask

  initial begin
    //            mode sel valid    rdy w2        ex_ready ex_val    grant vld
    tbl[0]  = '{1'b0, 3'd2, 4'b0100, 1'b1, 16'hBEEF, 4'b0100, 16'hBEEF, 3'd2, 1'b1};
    tbl[1]  = '{1'b0, 3'd5, 4'b1111, 1'b1, 16'hBEEF, 4'b0000, 16'hBEEF, 3'd2, 1'b0};
    tbl[2]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 16'h1002, 4'b0001, 16'h1000, 3'd0, 1'b1};
    tbl[3]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 16'h1002, 4'b0010, 16'h1001, 3'd1, 1'b1};
    tbl[4]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 16'h1002, 4'b0100, 16'h1002, 3'd2, 1'b1};
    tbl[5]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 16'h1002, 4'b1000, 16'h1003, 3'd3, 1'b1};
    tbl[6]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 16'h1002, 4'b0001, 16'h1000, 3'd0, 1'b1};
    tbl[7]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 16'h1002, 4'b0010, 16'h1001, 3'd1, 1'b1};
    tbl[8]  = '{1'b1, 3'd0, 4'b1111, 1'b0, 16'h1002, 4'b0000, 16'h1001, 3'd1, 1'b1};
    tbl[9]  = '{1'b1, 3'd0, 4'b1111, 1'b0, 16'h1002, 4'b0000, 16'h1001, 3'd1, 1'b1};
    tbl[10] = '{1'b1, 3'd0, 4'b1111, 1'b0, 16'h1002, 4'b0000, 16'h1001, 3'd1, 1'b1};
    tbl[11] = '{1'b1, 3'd0, 4'b1111, 1'b1, 16'h1002, 4'b0100, 16'h1002, 3'd2, 1'b1};
    tbl[12] = '{1'b1, 3'd0, 4'b0010, 1'b1, 16'h1002, 4'b0010, 16'h1001, 3'd1, 1'b1};
    tbl[13] = '{1'b1, 3'd0, 4'b1010, 1'b1, 16'h1002, 4'b1000, 16'h1003, 3'd3, 1'b1};
    tbl[14] = '{1'b1, 3'd0, 4'b1010, 1'b1, 16'h1002, 4'b0010, 16'h1001, 3'd1, 1'b1};
    tbl[15] = '{1'b1, 3'd0, 4'b0000, 1'b1, 16'h1002, 4'b0000, 16'h1001, 3'd1, 1'b0};
    tbl[16] = '{1'b0, 3'd1, 4'b1010, 1'b0, 16'h1002, 4'b0010, 16'h1001, 3'd1, 1'b1};
    tbl[17] = '{1'b1, 3'd0, 4'b1111, 1'b1, 16'h1002, 4'b0100, 16'h1002, 3'd2, 1'b1};
    tbl[18] = '{1'b0, 3'd3, 4'b0111, 1'b1, 16'h1002, 4'b0000, 16'h1002, 3'd2, 1'b0};

    // Reset with every channel valid: outputs and pop strobes must stay quiet.
    i_rst = 1'b1; i_mode = 1'b1; i_sel = '0; i_ready = 1'b1; i_valid = 4'b1111;
    i_val = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst.o_ready", 32'(o_ready), 32'h0);
    chk("rst.o_valid", 32'(o_valid), 32'h0);
    chk("rst.o_val", 32'(o_val), 32'h0);
    chk("rst.o_grant", 32'(o_grant), 32'h0);
    i_rst = 1'b0; i_valid = '0;
    #1;
    chk("rst_rel.o_valid", 32'(o_valid), 32'h0);
    @(posedge i_clk);
    #1;

    for (int v = 0; v < 19; v++) begin
      i_mode  = tbl[v].mode;
      i_sel   = tbl[v].sel;
      i_valid = tbl[v].valid;
      i_ready = tbl[v].rdy;
      i_val   = {16'h1003, tbl[v].w2, 16'h1001, 16'h1000};
      step($sformatf("vec%0d", v), tbl[v].ex_ready, tbl[v].ex_val, tbl[v].ex_grant, tbl[v].ex_valid);
    end

    // Reset mid-transfer: load ch3 (pointer at 3), then pulse reset between edges.
    i_mode = 1'b1; i_valid = 4'b1111; i_ready = 1'b0;
    step("mid_load", 4'b1000, 16'h1003, 3'd3, 1'b1);
    #3;
    i_rst = 1'b1;
    #1;
    chk("mid_rst.o_valid", 32'(o_valid), 32'h0);
    chk("mid_rst.o_val", 32'(o_val), 32'h0);
    chk("mid_rst.o_ready", 32'(o_ready), 32'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0; i_ready = 1'b1;
    step("post_rst", 4'b0001, 16'h1000, 3'd0, 1'b1);

`ifdef WORDMUX_ARB_LOCK_EN
    // Pointer is 1: lock onto ch1, starve ch0/ch2, then release and move on to ch2.
    i_lock = 1'b1; i_valid = 4'b0110;
    step("lock_set", 4'b0010, 16'h1001, 3'd1, 1'b1);
    i_valid = 4'b0111;
    step("lock_hold", 4'b0010, 16'h1001, 3'd1, 1'b1);
    i_valid = 4'b0101;
    step("lock_wait", 4'b0000, 16'h1001, 3'd1, 1'b0);
    i_valid = 4'b0111; i_lock = 1'b0;
    step("lock_rel", 4'b0010, 16'h1001, 3'd1, 1'b1);
    step("after_rel", 4'b0100, 16'h1002, 3'd2, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wordmux_arb.md
Name: wordmux_arb

Overview:
- Parametrised successor to the word multiplexers: selects one of CHANNELS input words of WIDTH bits per cycle into a one-entry registered output stage.
- Per-channel valid/ready on the inputs; valid/ready toward the consumer.
- Two modes: fixed select (software or decoder chooses the channel) and round-robin arbitration.
- Sits between register-file/ALU/immediate sources and the writeback or operand bus, where multiple producers share one 16-bit path.

Parameters:
- WIDTH, 16, data word width in bits
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select/grant index width; must satisfy 2**SEL_W >= CHANNELS

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_mode  input  1  0 = fixed select, 1 = round-robin
- i_sel  input  SEL_W  channel index used in fixed mode
- i_val  input  CHANNELS*WIDTH  flat input words; channel k occupies bits [k*WIDTH +: WIDTH]
- i_valid  input  CHANNELS  per-channel word valid
- o_ready  output  CHANNELS  per-channel pop strobe (combinational, at most one bit set)
- o_val  output  WIDTH  registered selected word
- o_valid  output  1  o_val holds an unconsumed word
- i_ready  input  1  consumer accepts o_val this cycle
- o_grant  output  SEL_W  registered index of the channel that supplied o_val

Behaviour:
- Reset (async, i_rst=1) values:
  - o_valid=0, o_val=0, o_grant=0, round-robin pointer r_ptr=0, lock flag cleared (if built).
  - o_ready forced to all-zero while i_rst=1.
- Load enable: ld = !o_valid || i_ready. Output register updates only when ld=1; otherwise o_val, o_grant and o_valid hold.
- Candidate selection, evaluated every cycle:
  - Fixed mode: candidate = i_sel, eligible iff i_sel < CHANNELS and i_valid[i_sel]=1. i_sel >= CHANNELS gives no candidate.
  - Round-robin mode: scan channels r_ptr, r_ptr+1, ... modulo CHANNELS; the first channel with i_valid=1 is the candidate.
- Grant (ld=1 and candidate k exists):
  - o_ready[k]=1 in the same cycle.
  - On the clock edge: o_val<=word k, o_grant<=k, o_valid<=1.
- ld=1 with no candidate: o_valid<=0; o_val and o_grant hold their last values.
- Round-robin pointer:
  - On a grant in round-robin mode, r_ptr <= (k+1) mod CHANNELS, with wrap from CHANNELS-1 to 0.
  - Unchanged in fixed mode and on cycles with no grant.
- Latency and throughput: input handshake to o_valid is 1 cycle. Sustained throughput is 1 word/cycle when i_ready is held at 1.
- Simultaneous events: consumer pop (o_valid && i_ready) and a new grant in the same cycle is legal; the register reloads with no bubble.
- Stall: o_valid=1 and i_ready=0 gives o_ready=0 for all channels; inputs must hold.
- Mode or i_sel changes take effect at the next arbitration decision. The word already held is not flushed.
- Reset mid-transfer discards the held word. Channels whose pop was not strobed keep their data.

Optional Feature:
- Macro: WORDMUX_ARB_LOCK_EN
- With the macro defined:
  - Adds port i_lock (input, 1).
  - Round-robin mode: a grant to channel k with i_lock=1 sets r_locked and records k. While r_locked=1, only k is eligible, and other channels wait even if valid.
  - A grant with i_lock=0 clears r_locked.
  - Fixed mode ignores i_lock and clears r_locked.
  - Reset clears r_locked.
- Without the macro: no i_lock port, no lock state; behaviour exactly as above.

Test Plan:
- Reset: assert i_rst with i_valid=4'b1111 -> o_ready=0000, o_valid=0, o_val=0x0000, o_grant=0; these values persist until the first edge after release.
- Fixed mode: i_mode=0, i_sel=2, ch2=0xBEEF valid, i_ready=1 -> o_ready=0100 in that cycle; next cycle o_val=0xBEEF, o_grant=2, o_valid=1. i_sel=5 with CHANNELS=4 -> no o_ready, o_valid drops to 0.
- Round-robin fairness:
  - Stimulus: i_mode=1, all four channels continuously valid (ch0..3 = 0x1000..0x1003), i_ready=1.
  - Required: grants 0,1,2,3,0,1 on consecutive cycles, with o_val following 0x1000, 0x1001, ..., and pointer wrap verified.
- Backpressure: o_valid=1, i_ready=0 for 3 cycles -> o_val/o_grant stable, o_ready=0000. Raising i_ready -> same-cycle reload, no bubble, no duplicated or lost word.
- Sparse RR: only ch3 and ch1 valid, r_ptr=2 -> ch3 is granted first, then ch1 (r_ptr=0 scan).
- Lock (WORDMUX_ARB_LOCK_EN defined): grant ch1 with i_lock=1 while ch0/ch2 are valid -> ch1 is regranted each cycle it is valid, and ch0/ch2 stall. The first ch1 grant with i_lock=0 releases the lock -> next grant goes to ch2.
